// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
// Pipeline sequencing controller for the 5-stage MIPS datapath.
// Detects load-use hazards, flushes wrong-path instructions after a taken
// branch resolved in EX, and freezes the front of the pipeline while a
// multi-cycle multiply occupies EX.
// Optional statistics counters are built when the macro HAZARD_STATS_EN is
// defined; otherwise Stall_Count and Flush_Count are tied to zero.

module hazard_stall_controller #(
   parameter int MUL_LATENCY = 4,
   parameter int CNT_W       = 4,
   parameter int STAT_W      = 16
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              ID_EX_MemRead,
   input  logic [4:0]        ID_EX_rt,
   input  logic [4:0]        IF_ID_rs,
   input  logic [4:0]        IF_ID_rt,
   input  logic              IF_ID_UsesRt,
   input  logic              Branch_Taken,
   input  logic              Mul_Start,
   output logic              PC_Write,
   output logic              IF_ID_Write,
   output logic              ID_EX_Write,
   output logic              IF_ID_Flush,
   output logic              ID_EX_Bubble,
   output logic              EX_MEM_Bubble,
   output logic              Mul_Done,
   output logic [STAT_W-1:0] Stall_Count,
   output logic [STAT_W-1:0] Flush_Count
);

   typedef enum logic {
      RUN      = 1'b0,
      MUL_WAIT = 1'b1
   } state_t;

   // Value loaded into the wait counter on Mul_Start: the Mul_Start cycle is
   // the first hold cycle, so MUL_WAIT needs MUL_LATENCY-2 more before release.
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY - 2);

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] next_cnt;
   logic             load_use;

   // Load-use hazard: a load in EX writes a register the ID instruction reads.
   always_comb begin
      load_use = ID_EX_MemRead && (ID_EX_rt != 5'd0) &&
                 ((IF_ID_rs == ID_EX_rt) ||
                  (IF_ID_UsesRt && (IF_ID_rt == ID_EX_rt)));
   end

   // State register and multiply wait counter.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
      end
   end

   // Next-state and Mealy outputs; everything is forced low while in reset.
   always_comb begin
      next_state    = state;
      next_cnt      = cnt;
      PC_Write      = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Write   = 1'b0;
      IF_ID_Flush   = 1'b0;
      ID_EX_Bubble  = 1'b0;
      EX_MEM_Bubble = 1'b0;
      Mul_Done      = 1'b0;

      case (state)
         RUN: begin
            PC_Write    = 1'b1;
            IF_ID_Write = 1'b1;
            ID_EX_Write = 1'b1;
            if (Branch_Taken) begin
               IF_ID_Flush  = 1'b1;
               ID_EX_Bubble = 1'b1;
            end else if (Mul_Start) begin
               PC_Write      = 1'b0;
               IF_ID_Write   = 1'b0;
               ID_EX_Write   = 1'b0;
               EX_MEM_Bubble = 1'b1;
               next_cnt      = CNT_LOAD;
               next_state    = MUL_WAIT;
            end else if (load_use) begin
               PC_Write     = 1'b0;
               IF_ID_Write  = 1'b0;
               ID_EX_Bubble = 1'b1;
            end
         end

         MUL_WAIT: begin
            if (cnt != '0) begin
               EX_MEM_Bubble = 1'b1;
               next_cnt      = cnt - CNT_W'(1);
            end else begin
               PC_Write    = 1'b1;
               IF_ID_Write = 1'b1;
               ID_EX_Write = 1'b1;
               Mul_Done    = 1'b1;
               next_state  = RUN;
            end
         end

         default: begin
            next_state = RUN;
            next_cnt   = '0;
         end
      endcase

      if (!Rst_n) begin
         PC_Write      = 1'b0;
         IF_ID_Write   = 1'b0;
         ID_EX_Write   = 1'b0;
         IF_ID_Flush   = 1'b0;
         ID_EX_Bubble  = 1'b0;
         EX_MEM_Bubble = 1'b0;
         Mul_Done      = 1'b0;
      end
   end

`ifdef HAZARD_STATS_EN
   logic [STAT_W-1:0] stall_cnt;
   logic [STAT_W-1:0] flush_cnt;
   logic              stall_ev;
   logic              flush_ev;

   // Both stall kinds (load-use and multiply hold) are exactly the cycles
   // where the PC is frozen; flushes are exactly the IF_ID_Flush cycles.
   always_comb begin
      stall_ev = Rst_n && !PC_Write;
      flush_ev = IF_ID_Flush;
   end

   // Saturating statistics counters, cleared only by reset.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_ev && (stall_cnt != '1))
            stall_cnt <= stall_cnt + STAT_W'(1);
         if (flush_ev && (flush_cnt != '1))
            flush_cnt <= flush_cnt + STAT_W'(1);
      end
   end

   assign Stall_Count = stall_cnt;
   assign Flush_Count = flush_cnt;
`else
   assign Stall_Count = '0;
   assign Flush_Count = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller
// Scoreboard bench: each stimulus step pushes its expected outputs and
// counter values; the scenario task pops and compares at the falling edge.

module tb_hazard_stall_controller;

   localparam int W = 4;

`ifdef HAZARD_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   // {PC_Write, IF_ID_Write, ID_EX_Write, IF_ID_Flush, ID_EX_Bubble, EX_MEM_Bubble, Mul_Done}
   localparam logic [6:0] C_DEF  = 7'b1110000;
   localparam logic [6:0] C_LU   = 7'b0010100;
   localparam logic [6:0] C_HOLD = 7'b0000010;
   localparam logic [6:0] C_BR   = 7'b1111100;
   localparam logic [6:0] C_DONE = 7'b1110001;
   localparam logic [6:0] C_RST  = 7'b0000000;

   typedef struct {
      logic       rst;
      logic       mr;
      logic [4:0] exrt;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       ur;
      logic       br;
      logic       mul;
      logic [6:0] ctl;
      logic       si;
      logic       fi;
   } vec_t;

   logic         Clk;
   logic         Rst_n;
   logic         ID_EX_MemRead;
   logic [4:0]   ID_EX_rt;
   logic [4:0]   IF_ID_rs;
   logic [4:0]   IF_ID_rt;
   logic         IF_ID_UsesRt;
   logic         Branch_Taken;
   logic         Mul_Start;
   logic         PC_Write;
   logic         IF_ID_Write;
   logic         ID_EX_Write;
   logic         IF_ID_Flush;
   logic         ID_EX_Bubble;
   logic         EX_MEM_Bubble;
   logic         Mul_Done;
   logic [W-1:0] Stall_Count;
   logic [W-1:0] Flush_Count;

   logic [14:0]  sb[$];
   logic [W-1:0] exp_stall;
   logic [W-1:0] exp_flush;
   int           total;
   int           bad;

   hazard_stall_controller #(
      .MUL_LATENCY(4),
      .CNT_W(4),
      .STAT_W(W)
   ) dut (
      .Clk(Clk),
      .Rst_n(Rst_n),
      .ID_EX_MemRead(ID_EX_MemRead),
      .ID_EX_rt(ID_EX_rt),
      .IF_ID_rs(IF_ID_rs),
      .IF_ID_rt(IF_ID_rt),
      .IF_ID_UsesRt(IF_ID_UsesRt),
      .Branch_Taken(Branch_Taken),
      .Mul_Start(Mul_Start),
      .PC_Write(PC_Write),
      .IF_ID_Write(IF_ID_Write),
      .ID_EX_Write(ID_EX_Write),
      .IF_ID_Flush(IF_ID_Flush),
      .ID_EX_Bubble(ID_EX_Bubble),
      .EX_MEM_Bubble(EX_MEM_Bubble),
      .Mul_Done(Mul_Done),
      .Stall_Count(Stall_Count),
      .Flush_Count(Flush_Count)
   );

   // Free-running 10 time-unit clock.
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   function automatic vec_t mk(input logic rst, input logic mr, input logic [4:0] exrt,
                               input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                               input logic br, input logic mul, input logic [6:0] ctl,
                               input logic si, input logic fi);
      vec_t v;
      v.rst = rst; v.mr = mr; v.exrt = exrt; v.rs = rs; v.rt = rt; v.ur = ur;
      v.br = br; v.mul = mul; v.ctl = ctl; v.si = si; v.fi = fi;
      return v;
   endfunction

   function automatic logic [14:0] observed();
      return {PC_Write, IF_ID_Write, ID_EX_Write, IF_ID_Flush, ID_EX_Bubble,
              EX_MEM_Bubble, Mul_Done, Stall_Count, Flush_Count};
   endfunction

   // Drive one cycle of stimulus after the rising edge and queue what must appear.
   task automatic applyStimulus(input vec_t v);
      @(posedge Clk);
      #1;
      Rst_n         = v.rst;
      ID_EX_MemRead = v.mr;
      ID_EX_rt      = v.exrt;
      IF_ID_rs      = v.rs;
      IF_ID_rt      = v.rt;
      IF_ID_UsesRt  = v.ur;
      Branch_Taken  = v.br;
      Mul_Start     = v.mul;
      if (!v.rst) begin
         exp_stall = '0;
         exp_flush = '0;
      end
      sb.push_back({v.ctl, (STATS ? exp_stall : W'(0)), (STATS ? exp_flush : W'(0))});
      if (v.si && (exp_stall != {W{1'b1}})) exp_stall = exp_stall + W'(1);
      if (v.fi && (exp_flush != {W{1'b1}})) exp_flush = exp_flush + W'(1);
   endtask

   task automatic test_reset();
      vec_t        v[$];
      logic [14:0] e;
      v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 0));
      v.push_back(mk(0, 1, 8, 8, 8, 1, 1, 1, C_RST, 0, 0));
      v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_DEF, 0, 0));
      foreach (v[i]) begin
         applyStimulus(v[i]);
         @(negedge Clk);
         e = sb.pop_front();
         total++;
         if (observed() !== e) begin
            bad++;
            $display("[TB] FAIL reset step %0d: got %b expected %b", i, observed(), e);
         end
      end
   endtask

   task automatic test_load_use();
      vec_t        v[$];
      logic [14:0] e;
      v.push_back(mk(1, 1, 8, 8, 0, 0, 0, 0, C_LU,  1, 0));
      v.push_back(mk(1, 0, 8, 8, 0, 0, 0, 0, C_DEF, 0, 0));
      v.push_back(mk(1, 1, 9, 3, 9, 1, 0, 0, C_LU,  1, 0));
      v.push_back(mk(1, 0, 9, 3, 9, 1, 0, 0, C_DEF, 0, 0));
      foreach (v[i]) begin
         applyStimulus(v[i]);
         @(negedge Clk);
         e = sb.pop_front();
         total++;
         if (observed() !== e) begin
            bad++;
            $display("[TB] FAIL load_use step %0d: got %b expected %b", i, observed(), e);
         end
      end
   endtask

   task automatic test_false_hazard();
      vec_t        v[$];
      logic [14:0] e;
      v.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, C_DEF, 0, 0));
      v.push_back(mk(1, 1, 8, 1, 8, 0, 0, 0, C_DEF, 0, 0));
      v.push_back(mk(1, 0, 8, 8, 8, 1, 0, 0, C_DEF, 0, 0));
      foreach (v[i]) begin
         applyStimulus(v[i]);
         @(negedge Clk);
         e = sb.pop_front();
         total++;
         if (observed() !== e) begin
            bad++;
            $display("[TB] FAIL false_hazard step %0d: got %b expected %b", i, observed(), e);
         end
      end
   endtask

   task automatic test_multiply();
      vec_t        v[$];
      logic [14:0] e;
      v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, C_HOLD, 1, 0));
      v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_HOLD, 1, 0));
      v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_HOLD, 1, 0));
      v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_DONE, 0, 0));
      v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_DEF,  0, 0));
      // Events during the hold are ignored and events in the release cycle are masked.
      v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, C_HOLD, 1, 0));
      v.push_back(mk(1, 1, 8, 8, 0, 0, 1, 1, C_HOLD, 1, 0));
      v.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, C_HOLD, 1, 0));
      v.push_back(mk(1, 1, 8, 8, 0, 0, 1, 1, C_DONE, 0, 0));
      v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_DEF,  0, 0));
      foreach (v[i]) begin
         applyStimulus(v[i]);
         @(negedge Clk);
         e = sb.pop_front();
         total++;
         if (observed() !== e) begin
            bad++;
            $display("[TB] FAIL multiply step %0d: got %b expected %b", i, observed(), e);
         end
      end
   endtask

   task automatic test_branch_priority();
      vec_t        v[$];
      logic [14:0] e;
      v.push_back(mk(1, 1, 8, 8, 0, 0, 1, 0, C_BR,  0, 1));
      v.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, C_BR,  0, 1));
      v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_DEF, 0, 0));
      v.push_back(mk(1, 1, 8, 5, 8, 1, 0, 1, C_HOLD, 1, 0));
      v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_HOLD, 1, 0));
      v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_HOLD, 1, 0));
      v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_DONE, 0, 0));
      foreach (v[i]) begin
         applyStimulus(v[i]);
         @(negedge Clk);
         e = sb.pop_front();
         total++;
         if (observed() !== e) begin
            bad++;
            $display("[TB] FAIL branch_priority step %0d: got %b expected %b", i, observed(), e);
         end
      end
   endtask

   task automatic test_back_to_back();
      vec_t        v[$];
      logic [14:0] e;
      v.push_back(mk(1, 1, 7, 7, 0, 0, 0, 0, C_LU,   1, 0));
      v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, C_HOLD, 1, 0));
      v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_HOLD, 1, 0));
      v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_HOLD, 1, 0));
      v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, C_DONE, 0, 0));
      v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, C_HOLD, 1, 0));
      v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_HOLD, 1, 0));
      v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_HOLD, 1, 0));
      v.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, C_DONE, 0, 0));
      v.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, C_BR,   0, 1));
      foreach (v[i]) begin
         applyStimulus(v[i]);
         @(negedge Clk);
         e = sb.pop_front();
         total++;
         if (observed() !== e) begin
            bad++;
            $display("[TB] FAIL back_to_back step %0d: got %b expected %b", i, observed(), e);
         end
      end
   endtask

   task automatic test_reset_mid_mul();
      vec_t        v[$];
      logic [14:0] e;
      v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, C_HOLD, 1, 0));
      v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_RST,  0, 0));
      v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_RST,  0, 0));
      v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_DEF,  0, 0));
      v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_DEF,  0, 0));
      foreach (v[i]) begin
         applyStimulus(v[i]);
         @(negedge Clk);
         e = sb.pop_front();
         total++;
         if (observed() !== e) begin
            bad++;
            $display("[TB] FAIL reset_mid_mul step %0d: got %b expected %b", i, observed(), e);
         end
      end
   endtask

   task automatic test_saturation();
      vec_t        v[$];
      logic [14:0] e;
      for (int k = 0; k < 20; k++)
         v.push_back(mk(1, 1, 12, 12, 0, 0, 0, 0, C_LU, 1, 0));
      v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_DEF, 0, 0));
      v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_DEF, 0, 0));
      foreach (v[i]) begin
         applyStimulus(v[i]);
         @(negedge Clk);
         e = sb.pop_front();
         total++;
         if (observed() !== e) begin
            bad++;
            $display("[TB] FAIL saturation step %0d: got %b expected %b", i, observed(), e);
         end
      end
   endtask

   // Scenario sequence followed by the summary line.
   initial begin
      total         = 0;
      bad           = 0;
      exp_stall     = '0;
      exp_flush     = '0;
      Rst_n         = 1'b1;
      ID_EX_MemRead = 1'b0;
      ID_EX_rt      = 5'd0;
      IF_ID_rs      = 5'd0;
      IF_ID_rt      = 5'd0;
      IF_ID_UsesRt  = 1'b0;
      Branch_Taken  = 1'b0;
      Mul_Start     = 1'b0;

      test_reset();
      test_load_use();
      test_false_hazard();
      test_multiply();
      test_branch_priority();
      test_back_to_back();
      test_reset_mid_mul();
      test_saturation();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
